// File: rtl/csa_limb_resolver.sv
// csa_limb_resolver
// Resolves the carry chain across the dual-result limb words from the
// conditional-sum adder. Each limb picks its sum and carry-out using the
// carry that the previous limb resolved. The final limb also reports the
// carry-out of the whole operation. An operation that reaches MAX_LIMBS
// limbs without in_last is closed early and flagged with out_err.
module csa_limb_resolver #(
    parameter int unsigned W         = 16,
    parameter int unsigned MAX_LIMBS = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [2*W+1:0]   in_word,
    input  logic             in_last,
    input  logic             in_cin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [W-1:0]     out_sum,
    output logic             out_last,
    output logic             out_cout,
    output logic             out_err
);

    localparam int unsigned CW = $clog2(MAX_LIMBS) + 1;

    typedef enum logic {
        IDLE,
        RUN
    } state_t;

    state_t         state_q, state_d;
    logic           carry_q, carry_d;
    logic [CW-1:0]  cnt_q, cnt_d;

    logic           in_xfer;
    logic           out_xfer;
    logic           c_sel;
    logic           nxt;
    logic [W-1:0]   sum_sel;
    logic           at_limit;
    logic           close_op;
    logic           forced;

    // A single output register means a new word can enter whenever the
    // register is empty or is being drained in the same cycle.
    assign in_ready = !out_valid || out_ready;

    // Pick this limb's result using the incoming carry, and decide whether the limb closes the operation.
    always_comb begin
        in_xfer  = in_valid && in_ready;
        out_xfer = out_valid && out_ready;
        c_sel    = (state_q == IDLE) ? in_cin : carry_q;
        sum_sel  = c_sel ? in_word[W-1:0] : in_word[2*W-1:W];
        nxt      = c_sel ? in_word[2*W+1] : in_word[2*W];
        at_limit = (state_q == RUN) && (cnt_q == CW'(MAX_LIMBS - 1));
        close_op = in_last || at_limit;
        forced   = at_limit && !in_last;
    end

    // Next-state logic: the carry, the limb count and the state advance only on an input transfer.
    always_comb begin
        state_d = state_q;
        carry_d = carry_q;
        cnt_d   = cnt_q;
        if (in_xfer) begin
            if (close_op) begin
                state_d = IDLE;
                carry_d = 1'b0;
                cnt_d   = '0;
            end else begin
                state_d = RUN;
                carry_d = nxt;
                cnt_d   = (state_q == IDLE) ? CW'(1) : cnt_q + CW'(1);
            end
        end
    end

    // State, carry and limb counter registers.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            carry_q <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            carry_q <= carry_d;
            cnt_q   <= cnt_d;
        end
    end

    // Output register: loads on every input transfer and empties when drained with no new limb arriving.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            out_sum   <= '0;
            out_last  <= 1'b0;
            out_cout  <= 1'b0;
            out_err   <= 1'b0;
        end else if (in_xfer) begin
            out_valid <= 1'b1;
            out_sum   <= sum_sel;
            out_last  <= close_op;
            out_cout  <= close_op && nxt;
            out_err   <= forced;
        end else if (out_xfer) begin
            out_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_csa_limb_resolver.sv
// Testbench for csa_limb_resolver. Operations are built from operand limbs.
// Expected results come from whole-operand arithmetic, split at the limb limit.
module tb_csa_limb_resolver;

    localparam int unsigned W         = 16;
    localparam int unsigned MAX_LIMBS = 8;

    logic            clk;
    logic            rst_n;
    logic            in_valid;
    logic            in_ready;
    logic [2*W+1:0]  in_word;
    logic            in_last;
    logic            in_cin;
    logic            out_valid;
    logic            out_ready;
    logic [W-1:0]    out_sum;
    logic            out_last;
    logic            out_cout;
    logic            out_err;

    csa_limb_resolver #(.W(W), .MAX_LIMBS(MAX_LIMBS)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_word   (in_word),
        .in_last   (in_last),
        .in_cin    (in_cin),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_sum   (out_sum),
        .out_last  (out_last),
        .out_cout  (out_cout),
        .out_err   (out_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic [2*W+1:0] w;
        logic           last;
        logic           cin;
    } in_item_t;

    typedef struct packed {
        logic [W-1:0] sum;
        logic         last;
        logic         cout;
        logic         err;
    } exp_item_t;

    in_item_t  in_q[$];
    exp_item_t exp_q[$];

    int unsigned n_checks = 0;
    int unsigned n_pass   = 0;

    logic        m_ov;
    logic        hold_pending;
    logic [W+2:0] held;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    // Queue one operation given its operand limbs. The adder's dual-result words are
    // formed from the operands. Expected results are the big-number sum, split into
    // chunks of at most MAX_LIMBS limbs.
    task automatic send_op(input int unsigned n, input logic cin0, input logic cin_trunc,
                           input logic [W-1:0] a[16], input logic [W-1:0] b[16]);
        logic [16:0]  t0, t1;
        in_item_t     it;
        exp_item_t    ex;
        logic [143:0] va, vb, vs;
        int unsigned  k;
        logic         ci;
        for (int unsigned j = 0; j < n; j++) begin
            t0 = 17'(a[j]) + 17'(b[j]);
            t1 = t0 + 17'd1;
            it.w    = {t1[16], t0[16], t0[15:0], t1[15:0]};
            it.last = (j == n - 1);
            if (j == 0) it.cin = cin0;
            else if (j % MAX_LIMBS == 0) it.cin = cin_trunc;
            else it.cin = 1'($urandom_range(1));
            in_q.push_back(it);
        end
        for (int unsigned s = 0; s < n; s += MAX_LIMBS) begin
            k  = (n - s < MAX_LIMBS) ? n - s : MAX_LIMBS;
            ci = (s == 0) ? cin0 : cin_trunc;
            va = '0;
            vb = '0;
            for (int unsigned i = 0; i < k; i++) begin
                va = va | (144'(a[s+i]) << (16 * i));
                vb = vb | (144'(b[s+i]) << (16 * i));
            end
            vs = va + vb + 144'(ci);
            for (int unsigned i = 0; i < k; i++) begin
                ex.sum  = vs[16*i +: 16];
                ex.last = (i == k - 1);
                ex.cout = (i == k - 1) ? vs[16*k] : 1'b0;
                ex.err  = (i == k - 1) && (s + k < n);
                exp_q.push_back(ex);
            end
        end
    endtask

    // Drive queued words and check every output transfer, under random gaps and backpressure.
    task automatic run_stream(input int unsigned ready_pct, input int unsigned valid_pct);
        int unsigned guard;
        logic        in_x, out_x;
        logic [63:0] r;
        exp_item_t   ex;
        guard = 0;
        while ((in_q.size() > 0 || exp_q.size() > 0) && guard < 4000) begin
            @(negedge clk);
            if (hold_pending) check("hold", {out_sum, out_last, out_cout, out_err}, held);
            out_ready = ($urandom_range(99) < ready_pct);
            if (in_q.size() > 0 && $urandom_range(99) < valid_pct) begin
                in_valid = 1'b1;
                in_word  = in_q[0].w;
                in_last  = in_q[0].last;
                in_cin   = in_q[0].cin;
            end else begin
                in_valid = 1'b0;
                r        = {$urandom(), $urandom()};
                in_word  = r[2*W+1:0];
                in_last  = r[40];
                in_cin   = r[41];
            end
            #1;
            check("out_valid", out_valid, m_ov);
            check("in_ready", in_ready, !m_ov || out_ready);
            out_x = out_valid && out_ready;
            in_x  = in_valid && in_ready;
            if (out_x) begin
                if (exp_q.size() == 0) begin
                    check("spurious_out", 1, 0);
                end else begin
                    ex = exp_q.pop_front();
                    check("out_sum", out_sum, ex.sum);
                    check("out_last", out_last, ex.last);
                    check("out_cout", out_cout, ex.cout);
                    check("out_err", out_err, ex.err);
                end
            end
            if (in_x) void'(in_q.pop_front());
            hold_pending = out_valid && !out_ready;
            held         = {out_sum, out_last, out_cout, out_err};
            m_ov         = in_x ? 1'b1 : (out_x ? 1'b0 : m_ov);
            guard++;
        end
        in_valid = 1'b0;
        if (guard >= 4000) check("stream_timeout", 0, 1);
    endtask

    logic [W-1:0] oa[16];
    logic [W-1:0] ob[16];
    int unsigned  nl;

    initial begin
        rst_n        = 1'b0;
        in_valid     = 1'b0;
        in_word      = '0;
        in_last      = 1'b0;
        in_cin       = 1'b0;
        out_ready    = 1'b0;
        m_ov         = 1'b0;
        hold_pending = 1'b0;
        held         = '0;
        repeat (2) @(negedge clk);
        check("rst_out_valid", out_valid, 0);
        check("rst_fields", {out_sum, out_last, out_cout, out_err}, 0);
        rst_n = 1'b1;
        #1;
        check("rst_in_ready", in_ready, 1);

        // Single limb 0xFFFF + 0x0001, cin=0
        oa[0] = 16'hFFFF; ob[0] = 16'h0001;
        send_op(1, 1'b0, 1'b0, oa, ob);
        run_stream(100, 100);

        // Two limbs 0x0000FFFF + 0x00000001
        oa[0] = 16'hFFFF; ob[0] = 16'h0001; oa[1] = 16'h0000; ob[1] = 16'h0000;
        send_op(2, 1'b0, 1'b0, oa, ob);
        run_stream(100, 100);

        // Carry-in chain over three 0xFFFF limbs, cin=1 and then cin=0
        for (int unsigned i = 0; i < 3; i++) begin oa[i] = 16'hFFFF; ob[i] = 16'h0000; end
        send_op(3, 1'b1, 1'b0, oa, ob);
        send_op(3, 1'b0, 1'b0, oa, ob);
        run_stream(100, 100);

        // Heavy backpressure
        for (int unsigned i = 0; i < 6; i++) begin oa[i] = 16'(i * 16'h3001); ob[i] = 16'hCFFF; end
        send_op(6, 1'b1, 1'b0, oa, ob);
        run_stream(15, 100);

        // Truncation: nine limbs with no close, and the ninth word carries its own cin
        for (int unsigned i = 0; i < 9; i++) begin oa[i] = 16'hFFFF; ob[i] = 16'h0000; end
        send_op(9, 1'b1, 1'b0, oa, ob);
        send_op(9, 1'b0, 1'b1, oa, ob);
        run_stream(70, 100);

        // Reset in the middle of an operation that also leaves a held output
        for (int unsigned i = 0; i < 4; i++) begin oa[i] = 16'hFFFF; ob[i] = 16'h0000; end
        send_op(4, 1'b1, 1'b0, oa, ob);
        run_stream(100, 100);
        @(negedge clk);
        rst_n = 1'b0;
        in_q.delete();
        exp_q.delete();
        @(negedge clk);
        rst_n = 1'b1;
        send_op(2, 1'b1, 1'b0, oa, ob);
        // Hold off the drain so that an output is still held when reset arrives
        in_q.delete();
        exp_q.delete();
        oa[0] = 16'hFFFF; ob[0] = 16'h0000;
        in_valid  = 1'b1;
        in_word   = {1'b1, 1'b0, 16'hFFFF, 16'h0000};
        in_last   = 1'b0;
        in_cin    = 1'b1;
        out_ready = 1'b0;
        @(negedge clk);
        in_valid = 1'b0;
        rst_n    = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check("midrst_out_valid", out_valid, 0);
        check("midrst_in_ready", in_ready, 1);
        m_ov         = 1'b0;
        hold_pending = 1'b0;
        send_op(1, 1'b0, 1'b0, oa, ob);
        run_stream(100, 100);

        // Random operations, some of them longer than the limb limit
        for (int unsigned t = 0; t < 40; t++) begin
            nl = $urandom_range(11, 1);
            for (int unsigned i = 0; i < 16; i++) begin
                oa[i] = 16'($urandom());
                ob[i] = ($urandom_range(3) == 0) ? ~oa[i] : 16'($urandom());
            end
            send_op(nl, 1'($urandom_range(1)), 1'($urandom_range(1)), oa, ob);
            if (t % 10 == 9) run_stream(30 + 20 * (t / 10), 60 + 10 * (t / 10));
        end
        run_stream(50, 80);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1);
    end

endmodule
